// File: rtl/apb_vga_text_pkg.sv
// Shared types and constants for the APB VGA text writer.
package apb_vga_text_pkg;

  // Default text screen geometry.
  localparam int DEFAULT_COLS = 80;
  localparam int DEFAULT_ROWS = 30;

  // Character written into every cell by CLEAR.
  localparam logic [7:0] SPACE_CHAR = 8'h20;

  // Command opcodes presented on cmd_op_i.
  typedef enum logic [1:0] {
    OP_PUTC   = 2'b00,
    OP_SETPOS = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_RSVD   = 2'b11
  } cmd_op_e;

  // Writer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_SETUP    = 2'b01,
    ST_ACCESS   = 2'b10,
    ST_CLR_NEXT = 2'b11
  } wr_state_e;

endpackage

// File: rtl/apb_vga_text_writer.sv
// Text-mode command front end that turns PUTC / SETPOS / CLEAR commands
// into APB write transfers towards a character frame buffer. One register
// serves both as the cursor and as the clear address walking the screen.
module apb_vga_text_writer
  import apb_vga_text_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int APB_DATA_WIDTH = 32,
  parameter int COLS           = DEFAULT_COLS,
  parameter int ROWS           = DEFAULT_ROWS
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  // command side
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [1:0]                cmd_op_i,
  input  logic [7:0]                cmd_char_i,
  input  logic [APB_ADDR_WIDTH-1:0] cmd_pos_i,
  // APB requester
  output logic [APB_ADDR_WIDTH-1:0] apb_paddr_o,
  output logic [APB_DATA_WIDTH-1:0] apb_pwdata_o,
  output logic                      apb_pwrite_o,
  output logic                      apb_psel_o,
  output logic                      apb_penable_o,
  input  logic [APB_DATA_WIDTH-1:0] apb_prdata_i,
  input  logic                      apb_pready_i,
  input  logic                      apb_pslverr_i,
  // status
  output logic [APB_ADDR_WIDTH-1:0] cursor_o,
  output logic                      busy_o,
  output logic [7:0]                err_cnt_o
);

  localparam int CELLS = COLS * ROWS;
  localparam logic [APB_ADDR_WIDTH-1:0] CELLS_A   = APB_ADDR_WIDTH'(CELLS);
  localparam logic [APB_ADDR_WIDTH-1:0] LAST_CELL = APB_ADDR_WIDTH'(CELLS - 1);
  localparam logic [APB_ADDR_WIDTH-1:0] ONE_A     = APB_ADDR_WIDTH'(1);

  wr_state_e                 state_reg;
  wr_state_e                 state_next;
  cmd_op_e                   op_reg;
  logic [APB_ADDR_WIDTH-1:0] cnt_reg;
  logic [APB_ADDR_WIDTH-1:0] cnt_inc;
  logic [APB_ADDR_WIDTH-1:0] paddr_reg;
  logic [APB_DATA_WIDTH-1:0] pwdata_reg;
  logic [7:0]                err_cnt_reg;

  cmd_op_e cmd_op;
  logic    cmd_fire;
  logic    xfer_done;
  logic    last_cell;
  logic    pos_oob;
  logic    err_event;

  // Read data is never consumed by a write-only requester.
  logic unused_prdata;
  assign unused_prdata = ^apb_prdata_i;

  assign cmd_op    = cmd_op_e'(cmd_op_i);
  assign cmd_ready_o = (state_reg == ST_IDLE) && !rst_i;
  assign cmd_fire  = cmd_valid_i && cmd_ready_o;
  assign xfer_done = (state_reg == ST_ACCESS) && apb_pready_i;
  assign last_cell = (cnt_reg == LAST_CELL);
  assign cnt_inc   = last_cell ? '0 : cnt_reg + ONE_A;
  assign pos_oob   = (cmd_pos_i >= CELLS_A);

  // All error sources are OR-ed so coincident errors count once.
  assign err_event = (cmd_fire && (cmd_op == OP_SETPOS) && pos_oob) ||
                     (cmd_fire && (cmd_op == OP_RSVD)) ||
                     (xfer_done && apb_pslverr_i);

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic: PUTC and CLEAR issue APB writes, the rest stay idle.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (cmd_fire && ((cmd_op == OP_PUTC) || (cmd_op == OP_CLEAR))) begin
          state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (apb_pready_i) begin
          state_next = (op_reg == OP_CLEAR) ? ST_CLR_NEXT : ST_IDLE;
        end
      end
      ST_CLR_NEXT: begin
        state_next = last_cell ? ST_IDLE : ST_SETUP;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: APB controls decoded purely from the registered state.
  always_comb begin
    apb_psel_o    = 1'b0;
    apb_penable_o = 1'b0;
    apb_pwrite_o  = 1'b0;
    busy_o        = 1'b1;
    unique case (state_reg)
      ST_IDLE: begin
        busy_o = 1'b0;
      end
      ST_SETUP: begin
        apb_psel_o   = 1'b1;
        apb_pwrite_o = 1'b1;
      end
      ST_ACCESS: begin
        apb_psel_o    = 1'b1;
        apb_penable_o = 1'b1;
        apb_pwrite_o  = 1'b1;
      end
      ST_CLR_NEXT: begin
        busy_o = 1'b1;
      end
      default: begin
        busy_o = 1'b1;
      end
    endcase
  end

  // Datapath: capture commands, move the shared cursor/clear counter,
  // and hold the APB address and data steady for the whole transfer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_reg     <= OP_PUTC;
      cnt_reg    <= '0;
      paddr_reg  <= '0;
      pwdata_reg <= '0;
    end else begin
      if (cmd_fire) begin
        op_reg <= cmd_op;
        case (cmd_op)
          OP_PUTC: begin
            paddr_reg  <= cnt_reg;
            pwdata_reg <= APB_DATA_WIDTH'(cmd_char_i);
          end
          OP_SETPOS: begin
            cnt_reg <= pos_oob ? '0 : cmd_pos_i;
          end
          OP_CLEAR: begin
            cnt_reg    <= '0;
            paddr_reg  <= '0;
            pwdata_reg <= APB_DATA_WIDTH'(SPACE_CHAR);
          end
          default: begin
          end
        endcase
      end
      // A finished PUTC advances the cursor, wrapping at the screen end.
      if (xfer_done && (op_reg == OP_PUTC)) begin
        cnt_reg <= cnt_inc;
      end
      // During CLEAR the counter walks the cells and lands on 0 after the last.
      if (state_reg == ST_CLR_NEXT) begin
        cnt_reg   <= cnt_inc;
        paddr_reg <= cnt_inc;
      end
    end
  end

  // Saturating error event counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_reg <= '0;
    end else if (err_event && (err_cnt_reg != 8'hFF)) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign apb_paddr_o  = paddr_reg;
  assign apb_pwdata_o = pwdata_reg;
  assign cursor_o     = cnt_reg;
  assign err_cnt_o    = err_cnt_reg;

endmodule

// File: tb/tb_apb_vga_text_writer.sv
// Directed testbench for apb_vga_text_writer with a configurable APB responder.
module tb_apb_vga_text_writer;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [7:0]    cmd_char;
  logic [AW-1:0] cmd_pos;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pwrite, psel, penable;
  logic [DW-1:0] prdata;
  logic          pready, pslverr;
  logic [AW-1:0] cursor;
  logic          busy;
  logic [7:0]    err_cnt;

  int chk_count = 0;
  int err_count = 0;

  // responder configuration
  int   wait_cfg   = 0;
  logic slverr_cfg = 1'b0;
  int   wait_cnt   = 0;

  always #5 clk = ~clk;

  apb_vga_text_writer dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_op_i      (cmd_op),
    .cmd_char_i    (cmd_char),
    .cmd_pos_i     (cmd_pos),
    .apb_paddr_o   (paddr),
    .apb_pwdata_o  (pwdata),
    .apb_pwrite_o  (pwrite),
    .apb_psel_o    (psel),
    .apb_penable_o (penable),
    .apb_prdata_i  (prdata),
    .apb_pready_i  (pready),
    .apb_pslverr_i (pslverr),
    .cursor_o      (cursor),
    .busy_o        (busy),
    .err_cnt_o     (err_cnt)
  );

  // APB responder: wait_cfg wait cycles per access, optional slave error.
  assign pready  = psel && penable && (wait_cnt >= wait_cfg);
  assign pslverr = slverr_cfg && pready;
  assign prdata  = 32'hDEAD_BEEF;

  always @(posedge clk) begin
    wait_cnt <= (psel && penable && !pready) ? wait_cnt + 1 : 0;
  end

  // Bus monitor: records completed writes and idle cycles following them.
  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  int pen_cycles = 0;
  int follow_ok  = 0;
  bit prev_wr    = 1'b0;

  always @(negedge clk) begin
    if (prev_wr && !psel) follow_ok++;
    prev_wr = psel && penable && pready;
    if (psel && penable) pen_cycles++;
    if (psel && penable && pready) begin
      wr_addr_q.push_back(paddr);
      wr_data_q.push_back(pwdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Present one command so it is accepted at the next rising edge, then scramble inputs.
  task automatic send(input logic [1:0] op, input logic [7:0] ch, input logic [AW-1:0] pos);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_char  = ch;
    cmd_pos   = pos;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b11;
    cmd_char  = 8'hFF;
    cmd_pos   = '1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < budget);
    check(tag, {31'b0, cmd_ready}, 32'd1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n;
    int guard;
    int bad;

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_char  = 8'h00;
    cmd_pos   = '0;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("ready_in_reset", {31'b0, cmd_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cursor", {20'b0, cursor}, 32'd0);
    check("rst_err", {24'b0, err_cnt}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_psel", {29'b0, psel, penable, pwrite}, 32'd0);
    check("rst_paddr", {20'b0, paddr}, 32'd0);
    check("rst_pwdata", pwdata, 32'd0);
    check("rst_ready", {31'b0, cmd_ready}, 32'd1);

    // ---------------- PUTC 'A', zero wait ----------------
    wait_cfg = 0;
    send(2'b00, 8'h41, '0);
    @(negedge clk);  // N+1: SETUP
    check("putc_setup_ctrl", {29'b0, psel, penable, pwrite}, 32'b101);
    check("putc_setup_paddr", {20'b0, paddr}, 32'd0);
    check("putc_setup_pwdata", pwdata, 32'h41);
    check("putc_setup_busy", {30'b0, busy, cmd_ready}, 32'b10);
    @(negedge clk);  // N+2: ACCESS
    check("putc_access_ctrl", {29'b0, psel, penable, pwrite}, 32'b111);
    check("putc_access_pwdata", pwdata, 32'h41);
    @(negedge clk);  // N+3: IDLE
    check("putc_ready_n3", {31'b0, cmd_ready}, 32'd1);
    check("putc_cursor", {20'b0, cursor}, 32'd1);
    check("putc_idle_ctrl", {29'b0, psel, penable, pwrite}, 32'd0);

    // ---------------- SETPOS 2399 + PUTC with one wait cycle ----------------
    wait_cfg = 1;
    send(2'b01, 8'h00, 12'd2399);
    @(negedge clk);
    check("setpos_cursor", {20'b0, cursor}, 32'd2399);
    check("setpos_no_busy", {30'b0, busy, psel}, 32'd0);
    send(2'b00, 8'h42, '0);
    pen_cycles = 0;
    wr_addr_q.delete();
    wr_data_q.delete();
    wait_idle("wait_putc_idle", 20);
    repeat (2) @(negedge clk);
    check("wait_access_cycles", pen_cycles, 32'd2);
    check("wait_wr_count", wr_addr_q.size(), 32'd1);
    check("wait_wr_addr", {20'b0, wr_addr_q[0]}, 32'd2399);
    check("wait_wr_data", wr_data_q[0], 32'h42);
    check("wrap_cursor", {20'b0, cursor}, 32'd0);

    // ---------------- slave error, bad SETPOS, reserved op ----------------
    wait_cfg   = 0;
    slverr_cfg = 1'b1;
    send(2'b00, 8'h43, '0);
    wait_idle("slverr_idle", 20);
    slverr_cfg = 1'b0;
    check("slverr_err", {24'b0, err_cnt}, 32'd1);
    check("slverr_cursor", {20'b0, cursor}, 32'd1);
    send(2'b01, 8'h00, 12'd3000);
    @(negedge clk);
    check("setpos3000_cursor", {20'b0, cursor}, 32'd0);
    check("setpos3000_err", {24'b0, err_cnt}, 32'd2);
    send(2'b11, 8'h55, '0);
    @(negedge clk);
    check("rsvd_err", {24'b0, err_cnt}, 32'd3);
    check("rsvd_idle", {29'b0, busy, psel, cmd_ready}, 32'b001);
    send(2'b01, 8'h00, 12'd2400);
    @(negedge clk);
    check("setpos2400_cursor", {20'b0, cursor}, 32'd0);
    check("setpos2400_err", {24'b0, err_cnt}, 32'd4);
    send(2'b01, 8'h00, 12'd5);
    @(negedge clk);
    check("setpos5_cursor", {20'b0, cursor}, 32'd5);
    check("setpos5_err", {24'b0, err_cnt}, 32'd4);

    // ---------------- full CLEAR ----------------
    send(2'b10, 8'h00, '0);
    wr_addr_q.delete();
    wr_data_q.delete();
    follow_ok = 0;
    busy_n = 0;
    guard  = 0;
    @(negedge clk);
    while (busy && guard < 8000) begin
      busy_n++;
      guard++;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check("clear_busy_cycles", busy_n, 32'd7200);
    check("clear_wr_count", wr_addr_q.size(), 32'd2400);
    bad = 0;
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      if (wr_addr_q[i] != AW'(i) || wr_data_q[i] != 32'h20) bad++;
    end
    check("clear_bad_writes", bad, 32'd0);
    check("clear_follow_idle", follow_ok, 32'd2400);
    check("clear_cursor", {20'b0, cursor}, 32'd0);
    check("clear_err", {24'b0, err_cnt}, 32'd4);

    // ---------------- reset during CLEAR at address 100 ----------------
    send(2'b10, 8'h00, '0);
    wr_addr_q.delete();
    wr_data_q.delete();
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(psel && !penable && paddr == 12'd100) && guard < 1000);
    check("abort_reach_100", {20'b0, paddr}, 32'd100);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ctrl", {29'b0, psel, penable, pwrite}, 32'd0);
    check("abort_paddr", {20'b0, paddr}, 32'd0);
    check("abort_pwdata", pwdata, 32'd0);
    check("abort_cursor", {20'b0, cursor}, 32'd0);
    check("abort_err", {24'b0, err_cnt}, 32'd0);
    check("abort_busy_ready", {30'b0, busy, cmd_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_wr_count", wr_addr_q.size(), 32'd100);
    check("abort_idle", {29'b0, busy, psel, cmd_ready}, 32'b001);

    // ---------------- error counter saturation ----------------
    for (int i = 0; i < 260; i++) send(2'b11, 8'h00, '0);
    @(negedge clk);
    check("err_saturate", {24'b0, err_cnt}, 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", chk_count, err_count);
    $finish;
  end

endmodule
